// File: rtl/pc_unit.sv
// Program-counter datapath: PCL/PCH select latches, 16-bit increment and bus drive.
// One PHI0 clock; an internal phase bit splits each pair of edges into sample and commit.
module pc_byte #(
   parameter int          VEC_W = 8,
   parameter logic [VEC_W-1:0] RST = '0
) (
   input  logic             PHI0,
   input  logic             n_RES,
   input  logic             sample,
   input  logic             commit,
   input  logic             freeze,
   input  logic             ld,
   input  logic             recirc,
   input  logic [VEC_W-1:0] bus,
   input  logic [VEC_W-1:0] nxt,
   output logic [VEC_W-1:0] sel,
   output logic [VEC_W-1:0] q
);
   always_ff @(posedge PHI0 or negedge n_RES) begin
      if (!n_RES) begin
         sel <= RST;
         q   <= RST;
      end else begin
         if (sample) begin
            // a stall reloads the select latch from the live PC so commit rewrites it unchanged
            if (freeze)      sel <= q;
            else if (ld)     sel <= bus;
            else if (recirc) sel <= q;
         end
         if (commit) q <= nxt;
      end
   end
endmodule

module pc_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        PHI0,
   input  logic        n_RES,
   input  logic        n_ready,
   input  logic        ADL_PCL,
   input  logic        PCL_PCL,
   input  logic        ADH_PCH,
   input  logic        PCH_PCH,
   input  logic        n_1PC,
   input  logic [7:0]  ADL,
   input  logic [7:0]  ADH,
   input  logic        PCL_ADL,
   input  logic        PCH_ADH,
   input  logic        PCL_DB,
   input  logic        PCH_DB,
   output logic        PHI1_o,
   output logic        PHI2_o,
   output logic [7:0]  ADL_out,
   output logic        ADL_oe,
   output logic [7:0]  ADH_out,
   output logic        ADH_oe,
   output logic [7:0]  DB_out,
   output logic        DB_oe,
   output logic [15:0] PC
);
   localparam int NUM_LANES = 2;
   localparam int VEC_W     = 8;
   localparam int PC_W      = NUM_LANES * VEC_W;

   logic ph;
   logic inc_latch;

   logic [NUM_LANES-1:0][VEC_W-1:0] lane_bus, lane_sel, lane_q, lane_nxt;
   logic [NUM_LANES-1:0]            lane_ld, lane_rc;

   always_ff @(posedge PHI0 or negedge n_RES) begin
      if (!n_RES) begin
         ph        <= 1'b0;
         inc_latch <= 1'b0;
      end else begin
         ph <= ~ph;
         if (!ph) inc_latch <= ~n_ready & ~n_1PC;
      end
   end

   assign lane_bus = {ADH, ADL};
   assign lane_ld  = {ADH_PCH, ADL_PCL};
   assign lane_rc  = {PCH_PCH, PCL_PCL};
   // full-width add gives the PCL->PCH carry and the FFFF->0000 wrap for free
   assign lane_nxt = lane_sel + {{(PC_W-1){1'b0}}, inc_latch};

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      pc_byte #(
         .VEC_W (VEC_W),
         .RST   (RESET_PC[i*VEC_W +: VEC_W])
      ) u_byte (
         .PHI0   (PHI0),
         .n_RES  (n_RES),
         .sample (~ph),
         .commit (ph),
         .freeze (n_ready),
         .ld     (lane_ld[i]),
         .recirc (lane_rc[i]),
         .bus    (lane_bus[i]),
         .nxt    (lane_nxt[i]),
         .sel    (lane_sel[i]),
         .q      (lane_q[i])
      );
   end

   assign PC     = lane_q;
   assign PHI1_o = ~ph;
   assign PHI2_o = ph;

   // enables are forced low while reset is held
   assign ADL_oe  = n_RES & PCL_ADL;
   assign ADH_oe  = n_RES & PCH_ADH;
   assign DB_oe   = n_RES & (PCL_DB | PCH_DB);
   assign ADL_out = ADL_oe ? lane_q[0] : 8'h00;
   assign ADH_out = ADH_oe ? lane_q[1] : 8'h00;
   assign DB_out  = !DB_oe ? 8'h00 : (PCL_DB ? lane_q[0] : lane_q[1]);
endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus random commands against a byte/word-level model.
module tb_pc_unit;
   localparam logic [15:0] RESET_PC = 16'h0000;

   logic PHI0 = 1'b0, n_RES = 1'b0, n_ready = 1'b0;
   logic ADL_PCL = 1'b0, PCL_PCL = 1'b0, ADH_PCH = 1'b0, PCH_PCH = 1'b0, n_1PC = 1'b1;
   logic [7:0] ADL = 8'h00, ADH = 8'h00;
   logic PCL_ADL = 1'b0, PCH_ADH = 1'b0, PCL_DB = 1'b0, PCH_DB = 1'b0;
   logic PHI1_o, PHI2_o, ADL_oe, ADH_oe, DB_oe;
   logic [7:0] ADL_out, ADH_out, DB_out;
   logic [15:0] PC;

   pc_unit #(.RESET_PC(RESET_PC)) dut (
      .PHI0(PHI0), .n_RES(n_RES), .n_ready(n_ready),
      .ADL_PCL(ADL_PCL), .PCL_PCL(PCL_PCL), .ADH_PCH(ADH_PCH), .PCH_PCH(PCH_PCH),
      .n_1PC(n_1PC), .ADL(ADL), .ADH(ADH),
      .PCL_ADL(PCL_ADL), .PCH_ADH(PCH_ADH), .PCL_DB(PCL_DB), .PCH_DB(PCH_DB),
      .PHI1_o(PHI1_o), .PHI2_o(PHI2_o),
      .ADL_out(ADL_out), .ADL_oe(ADL_oe), .ADH_out(ADH_out), .ADH_oe(ADH_oe),
      .DB_out(DB_out), .DB_oe(DB_oe), .PC(PC)
   );

   always #5 PHI0 = ~PHI0;

   int n_chk = 0, n_err = 0;
   logic [15:0] m_pc;
   logic [7:0]  m_sl, m_sh;
   logic        m_inc, m_ph;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_pc = RESET_PC; m_sl = RESET_PC[7:0]; m_sh = RESET_PC[15:8]; m_inc = 1'b0; m_ph = 1'b0;
   endtask

   // one PHI0 rising edge of the reference model
   task automatic m_edge();
      if (!m_ph) begin
         if (n_ready) begin
            m_sl = m_pc[7:0]; m_sh = m_pc[15:8]; m_inc = 1'b0;
         end else begin
            if (ADL_PCL) m_sl = ADL; else if (PCL_PCL) m_sl = m_pc[7:0];
            if (ADH_PCH) m_sh = ADH; else if (PCH_PCH) m_sh = m_pc[15:8];
            m_inc = !n_1PC;
         end
      end else begin
         m_pc = 16'((int'({m_sh, m_sl}) + int'(m_inc)) % 65536);
      end
      m_ph = !m_ph;
   endtask

   task automatic check_all();
      logic [7:0] e_db;
      e_db = 8'h00;
      if (n_RES && PCL_DB) e_db = m_pc[7:0];
      else if (n_RES && PCH_DB) e_db = m_pc[15:8];
      chk("pc", PC, m_pc);
      chk("phi1", 16'(PHI1_o), 16'(!m_ph));
      chk("phi2", 16'(PHI2_o), 16'(m_ph));
      chk("adl_oe", 16'(ADL_oe), 16'(n_RES & PCL_ADL));
      chk("adh_oe", 16'(ADH_oe), 16'(n_RES & PCH_ADH));
      chk("db_oe", 16'(DB_oe), 16'(n_RES & (PCL_DB | PCH_DB)));
      chk("adl_out", 16'(ADL_out), 16'((n_RES && PCL_ADL) ? m_pc[7:0] : 8'h00));
      chk("adh_out", 16'(ADH_out), 16'((n_RES && PCH_ADH) ? m_pc[15:8] : 8'h00));
      chk("db_out", 16'(DB_out), 16'(e_db));
   endtask

   task automatic step();
      @(posedge PHI0);
      m_edge();
      @(negedge PHI0);
      check_all();
   endtask

   task automatic pairs(input int n);
      repeat (2 * n) step();
   endtask

   task automatic cmd(input logic ldl, input logic rcl, input logic ldh, input logic rch,
                      input logic n1, input logic rdy);
      ADL_PCL = ldl; PCL_PCL = rcl; ADH_PCH = ldh; PCH_PCH = rch; n_1PC = n1; n_ready = rdy;
   endtask

   // one sample/commit pair loading v from the buses, then back to plain recirculate
   task automatic load(input logic [15:0] v, input logic n1);
      ADL = v[7:0]; ADH = v[15:8];
      cmd(1'b1, 1'b0, 1'b1, 1'b0, n1, 1'b0);
      pairs(1);
      cmd(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
   endtask

   logic [15:0] carry_seq [3];

   initial begin
      carry_seq[0] = 16'h00FF; carry_seq[1] = 16'h0100; carry_seq[2] = 16'h0101;
      m_reset();
      PCL_ADL = 1'b1; PCH_ADH = 1'b1; PCL_DB = 1'b1;
      #12;
      check_all();
      chk("rst_pc", PC, RESET_PC);
      @(negedge PHI0);
      n_RES = 1'b1; PCL_ADL = 1'b0; PCH_ADH = 1'b0; PCL_DB = 1'b0;
      chk("rel_phi1", 16'(PHI1_o), 16'h1);

      cmd(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("idle_phi1", 16'(PHI1_o), 16'(i % 2 == 1));
      end
      chk("idle_pc", PC, 16'h0000);

      load(16'h00FE, 1'b1);
      chk("ld_00fe", PC, 16'h00FE);
      n_1PC = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pairs(1);
         chk("carry", PC, carry_seq[i]);
      end

      load(16'hFFFF, 1'b0);
      chk("wrap", PC, 16'h0000);
      load(16'hFFFF, 1'b1);
      chk("ld_ffff", PC, 16'hFFFF);

      load(16'h1234, 1'b1);
      cmd(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      pairs(2);
      chk("stall", PC, 16'h1234);
      n_ready = 1'b0;
      pairs(1);
      chk("unstall", PC, 16'h1235);
      n_1PC = 1'b1;

      load(16'hABCD, 1'b1);
      PCL_DB = 1'b1; PCH_DB = 1'b1; PCL_ADL = 1'b1;
      #1;
      chk("db_pcl_wins", 16'(DB_out), 16'h00CD);
      chk("db_oe", 16'(DB_oe), 16'h1);
      chk("adl_cd", 16'(ADL_out), 16'h00CD);
      chk("adh_off", 16'(ADH_out), 16'h0000);
      chk("adh_oe_off", 16'(ADH_oe), 16'h0);
      PCL_DB = 1'b0;
      #1;
      chk("db_pch", 16'(DB_out), 16'h00AB);
      PCH_DB = 1'b0; PCL_ADL = 1'b0;

      load(16'h5555, 1'b1);
      ADL = 8'h77; ADH = 8'h77;
      cmd(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      n_RES = 1'b0;
      m_reset();
      #1;
      chk("midrst_pc", PC, RESET_PC);
      chk("midrst_phi1", 16'(PHI1_o), 16'h1);
      check_all();
      cmd(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      #2 n_RES = 1'b1;
      step();
      chk("post_rst_sample", 16'(PHI2_o), 16'h1);
      chk("post_rst_pc", PC, RESET_PC);
      step();

      for (int i = 0; i < 400; i++) begin
         ADL = 8'($urandom); ADH = 8'($urandom);
         cmd(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom_range(0, 3) == 0), $urandom_range(0, 3) == 0);
         PCL_ADL = 1'($urandom); PCH_ADH = 1'($urandom);
         PCL_DB = 1'($urandom); PCH_DB = 1'($urandom);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
